// File: rtl/risc_multicycle_sequencer.sv
// Multi-cycle control sequencer for the 16-bit RISC datapath: fetch, decode, execute,
// data-memory access and writeback, with illegal-opcode and memory-timeout traps.
// Optional performance counters are enabled by defining RISC_SEQ_PERF_EN.
module risc_multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_instr,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  input  logic        i_zero,
  output logic        o_ir_load,
  output logic        o_pc_inc,
  output logic        o_pc_branch,
  output logic        o_pc_jump,
  output logic        o_reg_wr,
  output logic        o_mem_to_reg,
  output logic [2:0]  o_state,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
`ifdef RISC_SEQ_PERF_EN
  ,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_retire_cnt
`endif
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } state_e;

  localparam logic [3:0] OpLw  = 4'd0;
  localparam logic [3:0] OpSw  = 4'd1;
  localparam logic [3:0] OpBeq = 4'd11;
  localparam logic [3:0] OpBne = 4'd12;
  localparam logic [3:0] OpJmp = 4'd13;

  localparam bit             TimeoutEn = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] ToLast   = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            trap_q, trap_d;
  logic [1:0]      cause_q, cause_d;
  logic            to_expired;

  logic unused_instr;
  assign unused_instr = ^i_instr[11:0];

  assign to_expired = TimeoutEn && (to_cnt_q == ToLast);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StFetch;
      op_q     <= 4'd0;
      to_cnt_q <= '0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      to_cnt_q <= to_cnt_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    unique case (state_q)
      StFetch: begin
        if (i_imem_ack) begin
          state_d = StDecode;
          op_d    = i_instr[15:12];
        end else if (to_expired) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end
      end
      StDecode: begin
        if (op_q >= 4'd14) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (op_q == OpLw || op_q == OpSw) begin
          state_d = StMem;
        end else if (op_q == OpBeq || op_q == OpBne || op_q == OpJmp) begin
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (i_dmem_ack) begin
          state_d = (op_q == OpSw) ? StFetch : StWb;
        end else if (to_expired) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'b11;
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase

    // Count only while waiting in a request state; any transition restarts the count.
    if (state_d == state_q && (state_q == StFetch || state_q == StMem)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = '0;
    end
  end

  // Output decode
  always_comb begin
    o_imem_req   = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_ir_load    = 1'b0;
    o_pc_inc     = 1'b0;
    o_pc_branch  = 1'b0;
    o_pc_jump    = 1'b0;
    o_reg_wr     = 1'b0;
    o_mem_to_reg = 1'b0;
    o_state      = 3'd0;
    o_trap       = 1'b0;
    o_trap_cause = 2'b00;
    if (!i_rst) begin
      o_state      = state_q;
      o_trap       = trap_q;
      o_trap_cause = cause_q;
      unique case (state_q)
        StFetch: begin
          o_imem_req = 1'b1;
          o_ir_load  = i_imem_ack;
        end
        StExec: begin
          if (op_q == OpJmp) begin
            o_pc_jump = 1'b1;
          end else if (op_q == OpBeq) begin
            o_pc_branch = i_zero;
            o_pc_inc    = ~i_zero;
          end else if (op_q == OpBne) begin
            o_pc_branch = ~i_zero;
            o_pc_inc    = i_zero;
          end
        end
        StMem: begin
          o_dmem_req = 1'b1;
          o_dmem_we  = (op_q == OpSw);
          o_pc_inc   = i_dmem_ack && (op_q == OpSw);
        end
        StWb: begin
          o_reg_wr     = 1'b1;
          o_pc_inc     = 1'b1;
          o_mem_to_reg = (op_q == OpLw);
        end
        default: ;
      endcase
    end
  end

`ifdef RISC_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q + ((state_q != StTrap) ? 32'd1 : 32'd0);
    retire_cnt_d = retire_cnt_q + ((o_pc_inc | o_pc_branch | o_pc_jump) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_cnt_q  <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign o_cycle_cnt  = cycle_cnt_q;
  assign o_retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_risc_multicycle_sequencer.sv
// Self-checking bench for risc_multicycle_sequencer: directed cases plus randomized
// instructions and memory wait times checked against a transaction-level model.
module tb_risc_multicycle_sequencer;

  localparam int unsigned MemTimeout = 15;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_instr = 16'h0000;
  logic        i_imem_ack = 1'b0;
  logic        i_dmem_ack = 1'b0;
  logic        i_zero = 1'b0;
  logic        o_imem_req, o_dmem_req, o_dmem_we, o_ir_load;
  logic        o_pc_inc, o_pc_branch, o_pc_jump, o_reg_wr, o_mem_to_reg;
  logic [2:0]  o_state;
  logic        o_trap;
  logic [1:0]  o_trap_cause;
`ifdef RISC_SEQ_PERF_EN
  logic [31:0] o_cycle_cnt, o_retire_cnt;
`endif

  risc_multicycle_sequencer #(
    .MEM_TIMEOUT(MemTimeout),
    .TO_W       (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_instr     (i_instr),
    .o_imem_req  (o_imem_req),
    .i_imem_ack  (i_imem_ack),
    .o_dmem_req  (o_dmem_req),
    .o_dmem_we   (o_dmem_we),
    .i_dmem_ack  (i_dmem_ack),
    .i_zero      (i_zero),
    .o_ir_load   (o_ir_load),
    .o_pc_inc    (o_pc_inc),
    .o_pc_branch (o_pc_branch),
    .o_pc_jump   (o_pc_jump),
    .o_reg_wr    (o_reg_wr),
    .o_mem_to_reg(o_mem_to_reg),
    .o_state     (o_state),
    .o_trap      (o_trap),
    .o_trap_cause(o_trap_cause)
`ifdef RISC_SEQ_PERF_EN
    ,
    .o_cycle_cnt (o_cycle_cnt),
    .o_retire_cnt(o_retire_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int imem_wait, dmem_wait, iw, dw;
  int st_log[64];
  int res_cyc, res_pc, res_ir, res_wr, res_m2r, res_dreq, res_dwe, res_wrinc, res_pulses;
  int res_cause;
  bit res_trap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: acks are driven at the falling edge, outputs read just after.
  // An ack on a port whose request is low is random noise the DUT must ignore.
  task automatic tick();
    @(negedge i_clk);
    i_imem_ack = o_imem_req ? (iw == imem_wait) : 1'($urandom_range(0, 1));
    i_dmem_ack = o_dmem_req ? (dw == dmem_wait) : 1'($urandom_range(0, 1));
    #1;
    if (o_imem_req) iw++;
    if (o_dmem_req) dw++;
  endtask

  task automatic do_reset();
    logic [14:0] outs;
    @(negedge i_clk);
    i_rst      = 1'b1;
    i_imem_ack = 1'b0;
    i_dmem_ack = 1'b0;
    #1;
    outs = {o_imem_req, o_dmem_req, o_dmem_we, o_ir_load, o_pc_inc, o_pc_branch, o_pc_jump,
            o_reg_wr, o_mem_to_reg, o_state, o_trap, o_trap_cause};
    check_eq("rst_outputs_zero", 32'(outs), 32'd0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    #1;
    check_eq("rst_state_fetch", 32'(o_state), 32'd0);
    check_eq("rst_imem_req", 32'(o_imem_req), 32'd1);
  endtask

  task automatic hold_trap(input int cycles, input int cause);
    int bad = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (o_imem_req || o_dmem_req || o_ir_load || o_pc_inc || o_pc_branch || o_pc_jump ||
          o_reg_wr || o_mem_to_reg || o_state != 3'd7 || !o_trap || o_trap_cause != cause)
        bad++;
    end
    check_eq("trap_hold_bad_cycles", 32'(bad), 32'd0);
  endtask

  // Runs one instruction from its first FETCH cycle to retirement or trap and compares the
  // observed transaction against what the instruction-level rules predict.
  task automatic run_txn(input logic [15:0] instr, input int iwait, input int dwait,
                         input bit zero, input int hold);
    int op = int'(instr[15:12]);
    bit is_mem = (op <= 1);
    int exp_cyc, exp_pc, exp_cause, exp_ir, exp_wr, exp_m2r, exp_dreq, exp_dwe, exp_pulses;
    bit done = 0;
    exp_pc = 0; exp_wr = 0; exp_m2r = 0; exp_dreq = 0; exp_ir = 1; exp_pulses = 0;
    if (iwait >= int'(MemTimeout)) begin
      exp_cause = 2; exp_cyc = int'(MemTimeout) + 1; exp_ir = 0;
    end else if (op >= 14) begin
      exp_cause = 1; exp_cyc = iwait + 3;
    end else if (is_mem && dwait >= int'(MemTimeout)) begin
      exp_cause = 3; exp_cyc = iwait + 4 + int'(MemTimeout); exp_dreq = int'(MemTimeout);
    end else begin
      exp_cause  = 0;
      exp_pulses = 1;
      if (op == 13) begin
        exp_cyc = iwait + 3; exp_pc = 3;
      end else if (op == 11) begin
        exp_cyc = iwait + 3; exp_pc = zero ? 2 : 1;
      end else if (op == 12) begin
        exp_cyc = iwait + 3; exp_pc = zero ? 1 : 2;
      end else if (op == 1) begin
        exp_cyc = iwait + 4 + dwait; exp_pc = 1; exp_dreq = dwait + 1;
      end else if (op == 0) begin
        exp_cyc = iwait + 5 + dwait; exp_pc = 1; exp_dreq = dwait + 1; exp_wr = 1; exp_m2r = 1;
      end else begin
        exp_cyc = iwait + 4; exp_pc = 1; exp_wr = 1;
      end
    end
    exp_dwe = (op == 1) ? exp_dreq : 0;

    i_instr = instr; i_zero = zero; imem_wait = iwait; dmem_wait = dwait; iw = 0; dw = 0;
    res_cyc = 0; res_pc = 0; res_ir = 0; res_wr = 0; res_m2r = 0; res_dreq = 0; res_dwe = 0;
    res_wrinc = 0; res_pulses = 0; res_cause = 0; res_trap = 0;
    for (int n = 1; n <= 64 && !done; n++) begin
      tick();
      st_log[n-1] = int'(o_state);
      if (n == 1) check_eq("txn_start_state", 32'(o_state), 32'd0);
      res_ir    += int'(o_ir_load);
      res_wr    += int'(o_reg_wr);
      res_m2r   += int'(o_mem_to_reg);
      res_dreq  += int'(o_dmem_req);
      res_dwe   += int'(o_dmem_req & o_dmem_we);
      res_wrinc += int'(o_reg_wr & o_pc_inc);
      if (o_pc_inc || o_pc_branch || o_pc_jump) begin
        done       = 1;
        res_cyc    = n;
        res_pulses = int'(o_pc_inc) + int'(o_pc_branch) + int'(o_pc_jump);
        res_pc     = o_pc_inc ? 1 : (o_pc_branch ? 2 : 3);
      end else if (o_trap) begin
        done      = 1;
        res_cyc   = n;
        res_trap  = 1;
        res_cause = int'(o_trap_cause);
      end
    end
    check_eq("latency", 32'(res_cyc), 32'(exp_cyc));
    check_eq("pc_kind", 32'(res_pc), 32'(exp_pc));
    check_eq("pc_pulses", 32'(res_pulses), 32'(exp_pulses));
    check_eq("trap_cause", 32'(res_cause), 32'(exp_cause));
    check_eq("ir_load_count", 32'(res_ir), 32'(exp_ir));
    check_eq("reg_wr_count", 32'(res_wr), 32'(exp_wr));
    check_eq("mem_to_reg_count", 32'(res_m2r), 32'(exp_m2r));
    check_eq("dmem_req_cycles", 32'(res_dreq), 32'(exp_dreq));
    check_eq("dmem_we_cycles", 32'(res_dwe), 32'(exp_dwe));
    if (res_trap) begin
      hold_trap(hold, exp_cause);
      do_reset();
    end
  endtask

  function automatic int pick_wait();
    int r = int'($urandom_range(0, 9));
    if (r < 7) return int'($urandom_range(0, 3));
    if (r == 7) return 14;
    if (r == 8) return 15;
    return 40;
  endfunction

  initial begin
    int found;
    logic [31:0] r;
    do_reset();

    // ALU op: state walk 0,1,2,4 with reg write and PC increment together in WB only.
    run_txn(16'h2A48, 0, 0, 1'b0, 0);
    check_eq("alu_st0", 32'(st_log[0]), 32'd0);
    check_eq("alu_st1", 32'(st_log[1]), 32'd1);
    check_eq("alu_st2", 32'(st_log[2]), 32'd2);
    check_eq("alu_st3", 32'(st_log[3]), 32'd4);
    check_eq("alu_wr_and_inc", 32'(res_wrinc), 32'd1);

    run_txn(16'h0A05, 0, 2, 1'b0, 0);  // LW, 7 cycles
    run_txn(16'hB203, 0, 0, 1'b1, 0);  // BEQ taken
    run_txn(16'hB203, 0, 0, 1'b0, 0);  // BEQ not taken
    run_txn(16'hC203, 0, 0, 1'b1, 0);  // BNE not taken
    run_txn(16'hD123, 1, 0, 1'b0, 0);  // JMP
    run_txn(16'hE000, 0, 0, 1'b0, 20); // illegal, held 20 cycles then reset
    run_txn(16'h1234, 0, 40, 1'b0, 3); // SW, dmem never acks
    run_txn(16'h1234, 0, 14, 1'b0, 0); // SW, ack on the last allowed cycle
    run_txn(16'h5000, 15, 0, 1'b0, 3); // imem timeout
    run_txn(16'h5000, 14, 0, 1'b0, 0); // imem ack on the last allowed cycle

    // Reset pulsed while waiting in MEM.
    i_instr = 16'h0A05; imem_wait = 0; dmem_wait = 100; iw = 0; dw = 0;
    found = 0;
    for (int n = 0; n < 10 && found == 0; n++) begin
      tick();
      if (o_state == 3'd3) found = 1;
    end
    check_eq("reach_mem", 32'(found), 32'd1);
    do_reset();

    for (int t = 0; t < 80; t++) begin
      r = $urandom();
      run_txn({r[15:12], r[11:0]}, pick_wait(), pick_wait(), r[16], 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/risc_multicycle_sequencer.md
Name: risc_multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the 16-bit RISC datapath: instruction fetch, decode, execute, data-memory access, register writeback.
- Drives IR load, PC update selects, register-file write enable and instruction/data memory request handshakes.
- Traps on illegal opcodes and on memory timeouts.
- Sits between the instruction/data memory ports and the existing decode/ALU control logic; owns when the combinational controls take effect.

Parameters:
- MEM_TIMEOUT, 15: max wait cycles for i_imem_ack / i_dmem_ack before trap; 0 disables timeout.
- TO_W, 4: timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_instr  in  16  instruction word; valid when i_imem_ack=1.
- o_imem_req  out  1  instruction fetch request.
- i_imem_ack  in  1  instruction fetch complete.
- o_dmem_req  out  1  data memory request.
- o_dmem_we  out  1  1 = store, 0 = load; valid with o_dmem_req.
- i_dmem_ack  in  1  data access complete.
- i_zero  in  1  ALU equality result, sampled in EXEC.
- o_ir_load  out  1  IR capture strobe.
- o_pc_inc  out  1  PC <= PC+1.
- o_pc_branch  out  1  PC <= PC+1+offset.
- o_pc_jump  out  1  PC <= jump target.
- o_reg_wr  out  1  register file write.
- o_mem_to_reg  out  1  writeback source is memory.
- o_state  out  3  current state encoding.
- o_trap  out  1  sticky trap flag.
- o_trap_cause  out  2  01 = illegal opcode, 10 = imem timeout, 11 = dmem timeout.

Behaviour:
- Clocking and reset: single clock i_clk. Reset i_rst is synchronous, active-high.
- Reset values: state = FETCH, op_q = 0, timeout counter = 0, o_trap = 0, o_trap_cause = 0.
- While i_rst=1, every output is forced to 0, including o_imem_req.
- Output timing: outputs decode combinationally from the state register and op_q. o_trap and o_trap_cause are registered.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Opcode map (instr[15:12]): 0 = LW, 1 = SW, 2-10 = ALU, 11 = BEQ, 12 = BNE, 13 = JMP, 14-15 = illegal.
- FETCH:
  - o_imem_req=1; hold until i_imem_ack.
  - On ack: o_ir_load=1 in the same cycle; op_q <= i_instr[15:12]; next state DECODE.
- DECODE: one cycle, no outputs. Opcode 14/15: TRAP with cause 01. Otherwise next state EXEC.
- EXEC: one cycle.
  - JMP: o_pc_jump=1, next FETCH.
  - BEQ: if i_zero, o_pc_branch=1; else o_pc_inc=1. Next FETCH.
  - BNE: if !i_zero, o_pc_branch=1; else o_pc_inc=1. Next FETCH.
  - LW/SW: next MEM.
  - ALU: next WB.
- MEM:
  - o_dmem_req=1; o_dmem_we = (op_q==SW).
  - On i_dmem_ack: SW asserts o_pc_inc=1 and goes to FETCH; LW goes to WB.
- WB: o_reg_wr=1, o_pc_inc=1, o_mem_to_reg = (op_q==LW); next FETCH.
- PC update rule: exactly one of o_pc_inc / o_pc_branch / o_pc_jump pulses per retired instruction, for one cycle.
- Latency with zero-wait acks:
  - branch/jump: 3 cycles.
  - ALU: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Timeout:
  - Counter clears on entry to FETCH or MEM and increments each cycle the request is unacked.
  - Ack arriving in the same cycle the count reaches MEM_TIMEOUT-1 wins; no trap.
  - Otherwise, at that count, next state is TRAP with cause 10 (FETCH) or 11 (MEM).
- Ack handling: an ack while the corresponding request is low is ignored.
- TRAP: all outputs 0 except o_trap=1, o_trap_cause and o_state. State is held until i_rst.
- Reset mid-operation: state returns to FETCH on the next edge; no partial PC/reg strobe is issued.

Optional Feature:
- Macro: RISC_SEQ_PERF_EN.
- When defined: adds ports o_cycle_cnt (out, 32) and o_retire_cnt (out, 32).
  - Both clear on reset.
  - o_cycle_cnt increments every non-TRAP cycle.
  - o_retire_cnt increments on each PC-update pulse.
  - Both wrap modulo 2^32.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ALU op 0x2A48, imem ack after 0 waits -> o_state 0,1,2,4,0; o_reg_wr and o_pc_inc high together only in the WB cycle.
- LW 0x0A05, dmem ack after 2 waits -> o_dmem_req high 3 cycles with o_dmem_we=0; then WB with o_mem_to_reg=1; 7 cycles total.
- BEQ 0xB203:
  - with i_zero=1 -> o_pc_branch=1, o_pc_inc=0.
  - with i_zero=0 -> o_pc_inc=1.
  - BNE 0xC203 with i_zero=1 -> o_pc_inc=1.
- Opcode 0xE000 -> TRAP after DECODE; o_trap=1, o_trap_cause=01; held 20 cycles with no strobes; i_rst clears to FETCH.
- SW with i_dmem_ack never asserted, MEM_TIMEOUT=15 -> TRAP after 15 MEM cycles, cause 11. Repeat with ack on the 15th cycle -> no trap, o_pc_inc=1.
- i_rst pulsed during MEM -> all outputs 0 that cycle; next cycle o_state=0, o_imem_req=1.
